// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - opcode, modifier, bus select and state encodings for the ALU sequencer
package matrix_pkg;

    localparam logic [2:0] NO_OP = 3'b000;
    localparam logic [2:0] LOAD  = 3'b001;
    localparam logic [2:0] ADD   = 3'b010;
    localparam logic [2:0] SUB   = 3'b011;
    localparam logic [2:0] SCALE = 3'b100;
    localparam logic [2:0] MATR  = 3'b101;

    localparam logic [2:0] REG_A  = 3'b001;
    localparam logic [2:0] C_TO_A = 3'b010;
    localparam logic [2:0] REG_B  = 3'b100;
    localparam logic [2:0] OUT    = 3'b111;

    localparam logic [1:0] BUS_NONE = 2'b00;
    localparam logic [1:0] BUS_MEM  = 2'b01;
    localparam logic [1:0] BUS_ALU  = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MEM_RD   = 3'd1,
        ALU_LOAD = 3'd2,
        ALU_EXEC = 3'd3,
        ALU_OUT  = 3'd4,
        DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction issue handshake between issuer and sequencer
interface alu_sequencer_if;
    logic [8:0] instr;
    logic       instr_valid;
    logic       instr_ready;

    modport master (output instr, output instr_valid, input instr_ready);
    modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - combinational instruction decode into first state and control flags
module seq_decode
    import matrix_pkg::*;
(
    input  logic [8:0] instr,
    output state_t     next_state,
    output logic       lat_mult,
    output logic       is_mem_load,
    output logic       is_out,
    output logic       illegal
);

    logic [2:0] opcode;
    logic [2:0] modifier;

    assign opcode   = instr[8:6];
    assign modifier = instr[5:3];

    // Unknown opcodes and LOAD modifiers fall through to DONE with illegal set
    always_comb begin
        next_state  = DONE;
        lat_mult    = (opcode == MATR);
        is_mem_load = 1'b0;
        is_out      = (modifier == OUT);
        illegal     = 1'b0;
        case (opcode)
            NO_OP: next_state = DONE;
            LOAD: begin
                if (modifier == REG_A || modifier == REG_B) begin
                    next_state  = MEM_RD;
                    is_mem_load = 1'b1;
                end else if (modifier == C_TO_A) begin
                    next_state = ALU_LOAD;
                end else begin
                    illegal = 1'b1;
                end
            end
            ADD, SUB, SCALE, MATR: next_state = ALU_EXEC;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - sequences memory reads, ALU ops and result writes per instruction
module alu_sequencer
    import matrix_pkg::*;
#(
    parameter int MULT_LAT  = 4,
    parameter int ARITH_LAT = 1
) (
    input  logic                  clk,
    input  logic                  nReset,
    alu_sequencer_if.slave        cmd,
    output logic [2:0]            alu_op_code,
    output logic [2:0]            alu_control,
    output logic                  nALU_Enable,
    output logic [2:0]            mem_addr,
    output logic                  mem_nRead,
    output logic                  mem_nWrite,
    output logic [1:0]            bus_src,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [3:0] MULT_CNT  = 4'(MULT_LAT - 1);
    localparam logic [3:0] ARITH_CNT = 4'(ARITH_LAT - 1);

    state_t     state, nxt_state, dec_state;
    logic [3:0] cnt, nxt_cnt;
    logic [8:0] instr_q, nxt_instr;
    logic       mem_load_q, out_q, illegal_q;
    logic       nxt_mem_load, nxt_out, nxt_illegal;
    logic       dec_lat_mult, dec_mem_load, dec_out, dec_illegal;
    logic       accept;

    logic [2:0] o_op, o_ctl, o_addr;
    logic       o_nen, o_nrd, o_nwr, o_done, o_err;
    logic [1:0] o_bus;

    assign cmd.instr_ready = (state == IDLE) && nReset;
    assign accept          = cmd.instr_valid && cmd.instr_ready;

    seq_decode u_decode (
        .instr       (cmd.instr),
        .next_state  (dec_state),
        .lat_mult    (dec_lat_mult),
        .is_mem_load (dec_mem_load),
        .is_out      (dec_out),
        .illegal     (dec_illegal)
    );

    // Next state, latency countdown and the instruction context the next cycle will use
    always_comb begin
        nxt_state    = state;
        nxt_cnt      = cnt;
        nxt_instr    = accept ? cmd.instr    : instr_q;
        nxt_mem_load = accept ? dec_mem_load : mem_load_q;
        nxt_out      = accept ? dec_out      : out_q;
        nxt_illegal  = accept ? dec_illegal  : illegal_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    nxt_state = dec_state;
                    nxt_cnt   = dec_lat_mult ? MULT_CNT : ARITH_CNT;
                end
            end
            MEM_RD:   nxt_state = ALU_LOAD;
            ALU_LOAD: nxt_state = DONE;
            ALU_EXEC: begin
                if (cnt == 4'd0) nxt_state = out_q ? ALU_OUT : DONE;
                else             nxt_cnt   = cnt - 4'd1;
            end
            ALU_OUT:  nxt_state = DONE;
            default:  nxt_state = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they can be registered alongside it
    always_comb begin
        o_nen  = 1'b1;
        o_op   = NO_OP;
        o_ctl  = 3'b000;
        o_nrd  = 1'b1;
        o_nwr  = 1'b1;
        o_bus  = BUS_NONE;
        o_addr = 3'b000;
        o_done = 1'b0;
        o_err  = 1'b0;
        case (nxt_state)
            MEM_RD: begin
                o_nrd  = 1'b0;
                o_addr = nxt_instr[2:0];
            end
            ALU_LOAD: begin
                o_nen = 1'b0;
                o_op  = LOAD;
                o_ctl = nxt_instr[5:3];
                o_bus = nxt_mem_load ? BUS_MEM : BUS_NONE;
            end
            ALU_EXEC: begin
                o_nen = 1'b0;
                o_op  = nxt_instr[8:6];
                o_ctl = nxt_instr[5:3];
            end
            ALU_OUT: begin
                o_nen  = 1'b0;
                o_op   = nxt_instr[8:6];
                o_ctl  = OUT;
                o_bus  = BUS_ALU;
                o_nwr  = 1'b0;
                o_addr = nxt_instr[2:0];
            end
            DONE: begin
                o_done = 1'b1;
                o_err  = nxt_illegal;
            end
            default: ;
        endcase
    end

    // State, context and registered outputs; reset drops every strobe at once
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            instr_q     <= 9'd0;
            mem_load_q  <= 1'b0;
            out_q       <= 1'b0;
            illegal_q   <= 1'b0;
            nALU_Enable <= 1'b1;
            alu_op_code <= NO_OP;
            alu_control <= 3'b000;
            mem_addr    <= 3'b000;
            mem_nRead   <= 1'b1;
            mem_nWrite  <= 1'b1;
            bus_src     <= BUS_NONE;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            instr_q     <= nxt_instr;
            mem_load_q  <= nxt_mem_load;
            out_q       <= nxt_out;
            illegal_q   <= nxt_illegal;
            nALU_Enable <= o_nen;
            alu_op_code <= o_op;
            alu_control <= o_ctl;
            mem_addr    <= o_addr;
            mem_nRead   <= o_nrd;
            mem_nWrite  <= o_nwr;
            bus_src     <= o_bus;
            busy        <= (nxt_state != IDLE);
            done        <= o_done;
            error       <= o_err;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer
module tb_alu_sequencer;

    localparam int MLAT = 4;
    localparam int ALAT = 2;

    logic       clk = 1'b0;
    logic       nReset = 1'b0;
    logic [2:0] alu_op_code, alu_control, mem_addr;
    logic       nALU_Enable, mem_nRead, mem_nWrite, busy, done, error;
    logic [1:0] bus_src;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int nwr_cnt = 0;

    logic [16:0] exp_q[$];
    logic [16:0] msk_q[$];

    typedef struct {
        logic [8:0] ins;
        int         lat;
        logic       err;
    } vec_t;
    vec_t tbl[13];

    alu_sequencer_if bus_if ();

    alu_sequencer #(.MULT_LAT(MLAT), .ARITH_LAT(ALAT)) dut (
        .clk         (clk),
        .nReset      (nReset),
        .cmd         (bus_if.slave),
        .alu_op_code (alu_op_code),
        .alu_control (alu_control),
        .nALU_Enable (nALU_Enable),
        .mem_addr    (mem_addr),
        .mem_nRead   (mem_nRead),
        .mem_nWrite  (mem_nWrite),
        .bus_src     (bus_src),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus_if.instr_valid && bus_if.instr_ready) acc_cnt <= acc_cnt + 1;
        if (!mem_nWrite) nwr_cnt <= nwr_cnt + 1;
    end

    function automatic logic [16:0] mk(logic nen, logic [2:0] op, logic [2:0] ctl, logic nrd, logic nwr,
                                       logic [1:0] bus, logic bsy, logic dn, logic er, logic [2:0] ad);
        return {nen, op, ctl, nrd, nwr, bus, bsy, dn, er, ad};
    endfunction

    function automatic logic [16:0] obs();
        return mk(nALU_Enable, alu_op_code, alu_control, mem_nRead, mem_nWrite, bus_src, busy, done, error, mem_addr);
    endfunction

    localparam logic [16:0] M_ALL  = 17'h1FFF8;
    localparam logic [16:0] M_ADDR = 17'h1FFFF;
    localparam logic [16:0] M_OUT  = 17'h10FFF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
        end
    endtask

    // Cycle-by-cycle expectation derived from the instruction's meaning
    task automatic build(input logic [8:0] ins);
        logic [2:0] op, m, a;
        logic       legal;
        int         lat;
        op = ins[8:6]; m = ins[5:3]; a = ins[2:0];
        exp_q.delete(); msk_q.delete();
        legal = (op == 3'd0) || (op == 3'd1 && (m == 3'd1 || m == 3'd2 || m == 3'd4)) || (op >= 3'd2 && op <= 3'd5);
        if (op == 3'd1 && (m == 3'd1 || m == 3'd4)) begin
            exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, a)); msk_q.push_back(M_ADDR);
            exp_q.push_back(mk(0, 1, m, 1, 1, 1, 1, 0, 0, 0)); msk_q.push_back(M_ALL);
        end else if (op == 3'd1 && m == 3'd2) begin
            exp_q.push_back(mk(0, 1, 2, 1, 1, 0, 1, 0, 0, 0)); msk_q.push_back(M_ALL);
        end else if (op >= 3'd2 && op <= 3'd5) begin
            lat = (op == 3'd5) ? MLAT : ALAT;
            repeat (lat) begin
                exp_q.push_back(mk(0, op, m, 1, 1, 0, 1, 0, 0, 0)); msk_q.push_back(M_ALL);
            end
            if (m == 3'd7) begin
                exp_q.push_back(mk(0, 0, 7, 1, 0, 2, 1, 0, 0, a)); msk_q.push_back(M_OUT);
            end
        end
        exp_q.push_back(mk(1, 0, 0, 1, 1, 0, 1, 1, !legal, 0)); msk_q.push_back(M_ALL);
    endtask

    task automatic issue(input logic [8:0] ins, output int done_c, output logic err_c);
        logic [16:0] o;
        int len;
        build(ins);
        len = exp_q.size();
        done_c = 0;
        err_c = 1'b0;
        @(negedge clk);
        bus_if.instr = ins;
        bus_if.instr_valid = 1'b1;
        chk($sformatf("ready_%03h", ins), bus_if.instr_ready, 1);
        @(negedge clk);
        bus_if.instr_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            o = obs();
            if (c <= len) chk($sformatf("cyc%0d_%03h", c, ins), o & msk_q[c-1], exp_q[c-1] & msk_q[c-1]);
            if (done && done_c == 0) begin
                done_c = c;
                err_c = error;
            end
            if (c >= len && done_c != 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        chk($sformatf("idle_%03h", ins), {bus_if.instr_ready, obs() & M_ALL}, {1'b1, mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0)});
    endtask

    initial begin
        int dc, d1, d2, nd;
        logic ec, r4, rbusy;
        bus_if.instr = 9'd0;
        bus_if.instr_valid = 1'b0;

        tbl[0]  = '{9'b000_000_000, 1, 1'b0};
        tbl[1]  = '{9'b110_000_000, 1, 1'b1};
        tbl[2]  = '{9'b111_101_011, 1, 1'b1};
        tbl[3]  = '{9'b001_000_000, 1, 1'b1};
        tbl[4]  = '{9'b001_111_000, 1, 1'b1};
        tbl[5]  = '{9'b001_001_000, 3, 1'b0};
        tbl[6]  = '{9'b001_100_101, 3, 1'b0};
        tbl[7]  = '{9'b001_010_000, 2, 1'b0};
        tbl[8]  = '{9'b010_000_011, ALAT + 1, 1'b0};
        tbl[9]  = '{9'b011_111_110, ALAT + 2, 1'b0};
        tbl[10] = '{9'b100_011_001, ALAT + 1, 1'b0};
        tbl[11] = '{9'b101_111_010, MLAT + 2, 1'b0};
        tbl[12] = '{9'b101_000_000, MLAT + 1, 1'b0};

        #12;
        chk("reset_outputs", {bus_if.instr_ready, obs() & M_ALL}, {1'b0, mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0)});
        @(negedge clk);
        nReset = 1'b1;
        #1;
        chk("ready_after_reset", bus_if.instr_ready, 1);

        foreach (tbl[i]) begin
            issue(tbl[i].ins, dc, ec);
            chk($sformatf("latency_%03h", tbl[i].ins), dc, tbl[i].lat);
            chk($sformatf("error_%03h", tbl[i].ins), ec, tbl[i].err);
        end

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(9'($urandom_range(0, 511)), dc, ec);
        end

        // valid held high across two instructions
        @(negedge clk);
        acc_cnt = 0;
        bus_if.instr = 9'b001_100_001;
        bus_if.instr_valid = 1'b1;
        @(negedge clk);
        bus_if.instr = 9'b010_111_011;
        nd = 0; d1 = 0; d2 = 0; r4 = 1'b0; rbusy = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 4) r4 = bus_if.instr_ready;
            if (c < 4 && bus_if.instr_ready) rbusy = 1'b1;
            if (done) begin
                nd++;
                if (nd == 1) d1 = c;
                else begin
                    d2 = c;
                    bus_if.instr_valid = 1'b0;
                    break;
                end
            end
            @(negedge clk);
        end
        bus_if.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_accepts", acc_cnt, 2);
        chk("b2b_first_done", d1, 3);
        chk("b2b_ready_c4", r4, 1);
        chk("b2b_ready_busy", rbusy, 0);
        chk("b2b_second_done", d2, 4 + ALAT + 2);

        // reset during the third MATR execute cycle
        nwr_cnt = 0;
        acc_cnt = 0;
        @(negedge clk);
        bus_if.instr = 9'b101_111_010;
        bus_if.instr_valid = 1'b1;
        @(negedge clk);
        bus_if.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_exec_enable", nALU_Enable, 0);
        nReset = 1'b0;
        #1;
        chk("reset_mid_outputs", {bus_if.instr_ready, obs() & M_ALL}, {1'b0, mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0)});
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) nd++;
        end
        nReset = 1'b1;
        #1;
        chk("ready_after_release", bus_if.instr_ready, 1);
        repeat (MLAT + 3) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abandon_no_write", nwr_cnt, 0);
        chk("abandon_no_done", nd, 0);
        chk("abandon_idle", {bus_if.instr_ready, busy}, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter MULT_LAT, default 4, cycles nALU_Enable is held low for a MATR (101) op; legal range 1..15.
REQ-002 Parameter ARITH_LAT, default 1, cycles nALU_Enable is held low for ADD (010), SUB (011) and SCALE (100); legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 nReset  input  1  asynchronous, active-low reset.
REQ-005 instr  input  9  instruction {opcode[8:6], modifier[5:3], addr[2:0]}.
REQ-006 instr_valid  input  1  instr is valid this cycle.
REQ-007 instr_ready  output  1  sequencer can accept an instruction.
REQ-008 alu_op_code  output  3  drives the ALU op_code.
REQ-009 alu_control  output  3  drives the ALU ALU_control.
REQ-010 nALU_Enable  output  1  active-low ALU enable.
REQ-011 mem_addr  output  3  operand or result memory address.
REQ-012 mem_nRead  output  1  active-low memory read strobe; read data is on dataBus the following cycle.
REQ-013 mem_nWrite  output  1  active-low memory write strobe; memory samples dataBus on that cycle.
REQ-014 bus_src  output  2  dataBus driver select: 00 none (Z), 01 memory, 10 ALU, 11 never driven.
REQ-015 busy  output  1  an instruction is in progress.
REQ-016 done  output  1  one-cycle pulse when an instruction retires.
REQ-017 error  output  1  one-cycle pulse, coincident with done, when the instruction was illegal.

Function
REQ-018 States: IDLE, MEM_RD, ALU_LOAD, ALU_EXEC, ALU_OUT, DONE.
REQ-019 instr_ready = 1 only in IDLE with nReset high; a transfer occurs on any edge where instr_valid and instr_ready are both 1, and instr is latched on that edge.
REQ-020 Decode on accept:
- NO_OP (000): go to DONE.
- LOAD (001) with modifier 001 or 100: go to MEM_RD.
- LOAD with modifier 010 (C to A): go to ALU_LOAD.
- 010, 011, 100, 101: go to ALU_EXEC.
- Any other opcode or LOAD modifier: go to DONE with error flagged.
REQ-021 MEM_RD, 1 cycle: mem_nRead=0, mem_addr=addr; next state ALU_LOAD.
REQ-022 ALU_LOAD, 1 cycle: nALU_Enable=0, alu_op_code=001, alu_control=modifier; bus_src=01 for a memory load, 00 for C to A; next state DONE.
REQ-023 ALU_EXEC: nALU_Enable=0, alu_op_code=opcode, alu_control=modifier, bus_src=00; held for exactly MULT_LAT (for 101) or ARITH_LAT cycles using a down-counter; then go to ALU_OUT if modifier==111, else DONE.
REQ-024 ALU_OUT, 1 cycle: bus_src=10, mem_nWrite=0, mem_addr=addr, nALU_Enable=0, alu_control=111; next state DONE.
REQ-025 DONE, 1 cycle: done=1, error as latched at decode; next state IDLE.
REQ-026 Outside the states listed above: nALU_Enable=1, mem_nRead=1, mem_nWrite=1, bus_src=00, alu_op_code=000, alu_control=000.
REQ-027 busy=1 in every state except IDLE.
REQ-028 mem_nRead and mem_nWrite are never low in the same cycle, and bus_src is never 11.
REQ-029 Latency from accept edge to done: NO_OP and illegal 1 cycle; LOAD from memory 3 cycles; C to A 2 cycles; ALU op LAT+1 cycles, or LAT+2 cycles with OUT.
REQ-030 instr_valid while busy is ignored and not queued; back-to-back issue gives one accept per DONE to IDLE return.

Reset
REQ-031 While nReset is low, asynchronously: state=IDLE, the counter and latched instr clear, instr_ready=0, busy=0, done=0, error=0, and all strobes and enables take their inactive values from REQ-026.
REQ-032 Reset mid-instruction abandons that instruction: no done, no write, and the bus is released in the same cycle.

Structure
REQ-033 Package matrix_pkg holds the opcode constants (NO_OP, LOAD, ADD, SUB, SCALE, MATR), the modifier constants (REG_A=001, C_TO_A=010, REG_B=100, OUT=111), the bus_src codes and the state encoding.
REQ-034 One sub-module, seq_decode: combinational instr to {next state, latency select, is_mem_load, is_out, illegal}.

Verification
REQ-035 Issue instr 001_001_000 -> mem_nRead low with mem_addr=0 on cycle 1; nALU_Enable low, op 001, control 001, bus_src=01 on cycle 2; done on cycle 3.
REQ-036 Issue instr 101_111_010 with MULT_LAT=4 -> nALU_Enable low for exactly 4 cycles with op 101; then mem_nWrite low, bus_src=10, mem_addr=2; done 6 cycles after accept.
REQ-037 Issue 000_xxx_xxx, then 110_000_000 -> done 1 cycle after each accept with no enable or strobe activity; error pulses only for the second.
REQ-038 Hold instr_valid high across the sequence 001_100_001, 010_111_011 -> exactly two accepts, the second on the first IDLE cycle after the first done.
REQ-039 Assert nReset low during the third ALU_EXEC cycle of a MATR op -> outputs go inactive immediately, no mem_nWrite occurs, and instr_ready=1 on the first edge after release.
